expr_recognizer: RTL and testbench

//   Streaming recognizer for ASCII arithmetic expressions, one character per accepted beat.

---
 rtl/expr_pkg.sv | 37 +++
 rtl/expr_char_class.sv | 25 ++
 rtl/expr_recognizer.sv | 114 +++++++++++
 tb/tb_expr_recognizer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared constants and types for the streaming expression recognizer.
package expr_pkg;

  // ASCII codes of the characters the recognizer understands
  localparam logic [7:0] CH_0     = 8'd48;
  localparam logic [7:0] CH_9     = 8'd57;
  localparam logic [7:0] CH_PLUS  = 8'd43;
  localparam logic [7:0] CH_MINUS = 8'd45;
  localparam logic [7:0] CH_MUL   = 8'd42;
  localparam logic [7:0] CH_DIV   = 8'd47;
  localparam logic [7:0] CH_LP    = 8'd40;
  localparam logic [7:0] CH_RP    = 8'd41;

  typedef enum logic [2:0] {
    C_DIGIT,
    C_OP,
    C_OPEN,
    C_CLOSE,
    C_ILL
  } char_class_e;

  typedef enum logic [1:0] {
    S_EXPECT,
    S_NUM,
    S_CLOSED,
    S_ERR
  } expr_state_e;

  function automatic logic char_is_digit(input logic [7:0] ch);
    return (ch >= CH_0) && (ch <= CH_9);
  endfunction

  function automatic logic char_is_op(input logic [7:0] ch);
    return (ch == CH_PLUS) || (ch == CH_MINUS) || (ch == CH_MUL) || (ch == CH_DIV);
  endfunction

endpackage

// File: rtl/expr_char_class.sv
// Combinational character classifier; brackets fold into ILLEGAL when disabled.
module expr_char_class
  import expr_pkg::*;
#(
  parameter bit ENABLE_PAREN = 1'b1
) (
  input  logic [7:0]  ch_i,
  output char_class_e cls_o
);

  // Priority decode of the incoming character into its class
  always_comb begin
    cls_o = C_ILL;
    if (char_is_digit(ch_i)) begin
      cls_o = C_DIGIT;
    end else if (char_is_op(ch_i)) begin
      cls_o = C_OP;
    end else if (ENABLE_PAREN && (ch_i == CH_LP)) begin
      cls_o = C_OPEN;
    end else if (ENABLE_PAREN && (ch_i == CH_RP)) begin
      cls_o = C_CLOSE;
    end
  end

endmodule

// File: rtl/expr_recognizer.sv
// Streaming recognizer for ASCII arithmetic expressions with bracket nesting,
// bounded operand length and a sticky error state.
module expr_recognizer
  import expr_pkg::*;
#(
  parameter int unsigned MAX_DEPTH    = 7,
  parameter int unsigned MAX_DIGITS   = 4,
  parameter bit          ENABLE_PAREN = 1'b1,
  localparam int unsigned DEPTH_W     = $clog2(MAX_DEPTH + 1),
  localparam int unsigned DCNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth
);

  localparam logic [DEPTH_W-1:0] DepthMax = DEPTH_W'(MAX_DEPTH);
  localparam logic [DCNT_W-1:0]  DcntMax  = DCNT_W'(MAX_DIGITS);

  char_class_e        cls;
  expr_state_e        state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic               out_q, err_q;

  expr_char_class #(
    .ENABLE_PAREN(ENABLE_PAREN)
  ) u_char_class (
    .ch_i (in),
    .cls_o(cls)
  );

  // Next-state decode; anything that would leave ERR or over/underflow a
  // counter lands in ERR with the counters left at their current values.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    dcnt_d  = dcnt_q;
    if (in_valid) begin
      unique case (state_q)
        S_EXPECT: begin
          if (cls == C_DIGIT) begin
            state_d = S_NUM;
            dcnt_d  = DCNT_W'(1);
          end else if (cls == C_OPEN) begin
            if (depth_q == DepthMax) begin
              state_d = S_ERR;
            end else begin
              depth_d = depth_q + 1'b1;
              dcnt_d  = '0;
            end
          end else begin
            state_d = S_ERR;
          end
        end
        S_NUM, S_CLOSED: begin
          if ((cls == C_DIGIT) && (state_q == S_NUM)) begin
            if (dcnt_q == DcntMax) begin
              state_d = S_ERR;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end else if (cls == C_OP) begin
            state_d = S_EXPECT;
            dcnt_d  = '0;
          end else if (cls == C_CLOSE) begin
            if (depth_q == '0) begin
              state_d = S_ERR;
            end else begin
              state_d = S_CLOSED;
              depth_d = depth_q - 1'b1;
              dcnt_d  = '0;
            end
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_ERR;
        end
      endcase
    end
  end

  // State, counters and flags; flags are decoded from the next state so they
  // match the Moore view of the registers after the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_EXPECT;
      depth_q <= '0;
      dcnt_q  <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      dcnt_q  <= dcnt_d;
      out_q   <= ((state_d == S_NUM) || (state_d == S_CLOSED)) && (depth_d == '0);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign out   = out_q;
  assign err   = err_q;
  assign depth = depth_q;

endmodule

// File: tb/tb_expr_recognizer.sv
// Scenario bench for expr_recognizer: expected {out, err, depth} pushed on drive,
// popped and compared one cycle later.
module tb_expr_recognizer;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_ch = 8'd0;
  logic       out, err;
  logic [2:0] depth;
  logic       out2, err2;
  logic [2:0] depth2;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       c;
    logic       v;
    logic [7:0] ch;
    logic [4:0] e;
  } beat_t;

  logic [4:0] sb_q[$];

  always #5 clk = ~clk;

  expr_recognizer #(
    .MAX_DEPTH(7), .MAX_DIGITS(4), .ENABLE_PAREN(1'b1)
  ) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .out(out), .err(err), .depth(depth)
  );

  expr_recognizer #(
    .MAX_DEPTH(7), .MAX_DIGITS(4), .ENABLE_PAREN(1'b0)
  ) dut_np (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .out(out2), .err(err2), .depth(depth2)
  );

  function automatic logic [4:0] ex(input logic o, input logic e, input int d);
    return {o, e, 3'(d)};
  endfunction

  function automatic beat_t bt(input logic c, input logic v, input logic [7:0] ch,
                               input logic [4:0] e);
    return '{c: c, v: v, ch: ch, e: e};
  endfunction

  // Drive one beat just after an edge, record its expectation, then wait for
  // the edge that consumes it and settle.
  task automatic apply(input beat_t b);
    clr      = b.c;
    in_valid = b.v;
    in_ch    = b.ch;
    sb_q.push_back(b.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    apply(bt(1, 0, 8'd0, ex(0, 0, 0)));
    e = sb_q.pop_front();
    checks++;
    if ({out, err, depth} !== e) begin
      failures++;
      $display("FAIL reset got=%b want=%b", {out, err, depth}, e);
    end
    checks++;
    if ({out2, err2, depth2} !== 5'b0) begin
      failures++;
      $display("FAIL reset_np got=%b want=%b", {out2, err2, depth2}, 5'b0);
    end
  endtask

  task automatic test_mul();
    beat_t s[$];
    logic [4:0] e;
    s = {bt(1, 0, 0, ex(0, 0, 0)), bt(0, 1, 49, ex(1, 0, 0)), bt(0, 1, 42, ex(0, 0, 0)),
         bt(0, 1, 49, ex(1, 0, 0))};
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      checks++;
      if ({out, err, depth} !== e) begin
        failures++;
        $display("FAIL mul[%0d] got=%b want=%b", i, {out, err, depth}, e);
      end
    end
  endtask

  task automatic test_paren();
    beat_t s[$];
    logic [4:0] e;
    s = {bt(1, 0, 0, ex(0, 0, 0)), bt(0, 1, 40, ex(0, 0, 1)), bt(0, 1, 49, ex(0, 0, 1)),
         bt(0, 1, 50, ex(0, 0, 1)), bt(0, 1, 43, ex(0, 0, 1)), bt(0, 1, 51, ex(0, 0, 1)),
         bt(0, 1, 41, ex(1, 0, 0))};
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      checks++;
      if ({out, err, depth} !== e) begin
        failures++;
        $display("FAIL paren[%0d] got=%b want=%b", i, {out, err, depth}, e);
      end
    end
  endtask

  task automatic test_underflow();
    beat_t s[$];
    logic [4:0] e;
    s = {bt(1, 0, 0, ex(0, 0, 0)), bt(0, 1, 49, ex(1, 0, 0)), bt(0, 1, 41, ex(0, 1, 0))};
    for (int k = 0; k < 5; k++) s.push_back(bt(0, 0, 49, ex(0, 1, 0)));
    s.push_back(bt(1, 1, 49, ex(0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      checks++;
      if ({out, err, depth} !== e) begin
        failures++;
        $display("FAIL underflow[%0d] got=%b want=%b", i, {out, err, depth}, e);
      end
    end
  endtask

  task automatic test_limits();
    beat_t s[$];
    logic [4:0] e;
    s = {bt(1, 0, 0, ex(0, 0, 0))};
    for (int k = 1; k <= 7; k++) s.push_back(bt(0, 1, 40, ex(0, 0, k)));
    s.push_back(bt(0, 1, 40, ex(0, 1, 7)));
    s.push_back(bt(0, 1, 41, ex(0, 1, 7)));
    s.push_back(bt(1, 0, 0, ex(0, 0, 0)));
    for (int k = 0; k < 4; k++) s.push_back(bt(0, 1, 8'(49 + k), ex(1, 0, 0)));
    s.push_back(bt(0, 1, 53, ex(0, 1, 0)));
    s.push_back(bt(1, 0, 0, ex(0, 0, 0)));
    for (int k = 0; k < 4; k++) s.push_back(bt(0, 1, 48, ex(1, 0, 0)));
    s.push_back(bt(0, 1, 47, ex(0, 0, 0)));
    s.push_back(bt(0, 1, 57, ex(1, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      checks++;
      if ({out, err, depth} !== e) begin
        failures++;
        $display("FAIL limits[%0d] got=%b want=%b", i, {out, err, depth}, e);
      end
    end
  endtask

  task automatic test_valid_hold();
    beat_t s[$];
    logic [4:0] e;
    s = {bt(1, 0, 0, ex(0, 0, 0)), bt(0, 1, 49, ex(1, 0, 0)), bt(0, 1, 43, ex(0, 0, 0)),
         bt(0, 0, 49, ex(0, 0, 0)), bt(0, 0, 49, ex(0, 0, 0)), bt(0, 0, 49, ex(0, 0, 0)),
         bt(0, 1, 50, ex(1, 0, 0)), bt(0, 1, 45, ex(0, 0, 0)), bt(0, 1, 40, ex(0, 0, 1)),
         bt(0, 0, 41, ex(0, 0, 1)), bt(0, 1, 55, ex(0, 0, 1)), bt(0, 1, 41, ex(1, 0, 0))};
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      checks++;
      if ({out, err, depth} !== e) begin
        failures++;
        $display("FAIL valid_hold[%0d] got=%b want=%b", i, {out, err, depth}, e);
      end
    end
  endtask

  task automatic test_illegal();
    beat_t s[$];
    logic [4:0] e;
    s = {bt(1, 0, 0, ex(0, 0, 0)), bt(0, 1, 45, ex(0, 1, 0)),
         bt(1, 0, 0, ex(0, 0, 0)), bt(0, 1, 40, ex(0, 0, 1)), bt(0, 1, 49, ex(0, 0, 1)),
         bt(0, 1, 41, ex(1, 0, 0)), bt(0, 1, 50, ex(0, 1, 0)),
         bt(1, 0, 0, ex(0, 0, 0)), bt(0, 1, 49, ex(1, 0, 0)), bt(0, 1, 97, ex(0, 1, 0)),
         bt(1, 0, 0, ex(0, 0, 0)), bt(0, 1, 49, ex(1, 0, 0)), bt(0, 1, 40, ex(0, 1, 0))};
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      checks++;
      if ({out, err, depth} !== e) begin
        failures++;
        $display("FAIL illegal[%0d] got=%b want=%b", i, {out, err, depth}, e);
      end
    end
  endtask

  task automatic test_clr_wins();
    beat_t s[$];
    logic [4:0] e;
    s = {bt(1, 0, 0, ex(0, 0, 0)), bt(0, 1, 40, ex(0, 0, 1)), bt(0, 1, 49, ex(0, 0, 1)),
         bt(1, 1, 49, ex(0, 0, 0)), bt(0, 1, 49, ex(1, 0, 0))};
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      checks++;
      if ({out, err, depth} !== e) begin
        failures++;
        $display("FAIL clr_wins[%0d] got=%b want=%b", i, {out, err, depth}, e);
      end
    end
  endtask

  task automatic test_no_paren();
    beat_t s[$];
    logic [4:0] e;
    s = {bt(1, 0, 0, ex(0, 0, 0)), bt(0, 1, 49, ex(1, 0, 0)), bt(0, 1, 43, ex(0, 0, 0)),
         bt(0, 1, 50, ex(1, 0, 0)), bt(1, 0, 0, ex(0, 0, 0)), bt(0, 1, 40, ex(0, 1, 0)),
         bt(1, 0, 0, ex(0, 0, 0)), bt(0, 1, 49, ex(1, 0, 0)), bt(0, 1, 41, ex(0, 1, 0))};
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      checks++;
      if ({out2, err2, depth2} !== e) begin
        failures++;
        $display("FAIL no_paren[%0d] got=%b want=%b", i, {out2, err2, depth2}, e);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_mul();
    test_paren();
    test_underflow();
    test_limits();
    test_valid_hold();
    test_illegal();
    test_clr_wins();
    test_no_paren();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
